// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver using a 16x oversampling tick.
// The RX pin is synchronised through two flops. A start bit is recognised
// only on a 1->0 transition of the synchronised line, so a held-low line
// (break) cannot retrigger reception. Good bytes are presented on o_dout
// with a one-cycle done strobe; a low stop bit gives a one-cycle frame error
// strobe instead.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_rx,
    input  logic            i_s_tick,
    output logic [DBIT-1:0] o_dout,
    output logic            o_rx_done_tick,
    output logic            o_frame_err
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              prev_q, prev_d;
    logic [3:0]        s_cnt_q, s_cnt_d;
    logic [NW-1:0]     n_cnt_q, n_cnt_d;
    logic [DBIT-1:0]   shift_q, shift_d;
    logic [DBIT-1:0]   dout_q, dout_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic              rx_s;

    assign rx_s           = sync2_q;
    assign o_dout         = dout_q;
    assign o_rx_done_tick = done_q;
    assign o_frame_err    = ferr_q;

    // Next-state logic: synchroniser, edge history, receive FSM and output strobes.
    always_comb begin
        sync1_d = i_rx;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a falling edge starts a frame; ticks are irrelevant here.
                if (!rx_s && prev_q) begin
                    state_d = START;
                    s_cnt_d = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (i_s_tick) begin
                    if (s_cnt_q == 4'd7) begin
                        // Middle of the start bit: confirm it is still low.
                        if (!rx_s) begin
                            state_d = DATA;
                            s_cnt_d = 4'd0;
                            n_cnt_d = {NW{1'b0}};
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end else begin
                    s_cnt_d = s_cnt_q;
                end
            end
            DATA: begin
                if (i_s_tick) begin
                    if (s_cnt_q == 4'd15) begin
                        // Middle of a data bit: LSB arrives first, shift in from the top.
                        shift_d = {rx_s, shift_q[DBIT-1:1]};
                        s_cnt_d = 4'd0;
                        if (n_cnt_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + {{(NW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end else begin
                    s_cnt_d = s_cnt_q;
                end
            end
            STOP: begin
                if (i_s_tick) begin
                    if (s_cnt_q == 4'(SB_TICK - 1)) begin
                        // Stop bit decides between a good byte and a framing error.
                        state_d = IDLE;
                        if (rx_s) begin
                            dout_d = shift_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end else begin
                    s_cnt_d = s_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset taking priority over all updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            s_cnt_q <= 4'd0;
            n_cnt_q <= {NW{1'b0}};
            shift_q <= {DBIT{1'b0}};
            dout_q  <= {DBIT{1'b0}};
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the UART path; directly upstream of the operand/opcode interface block.
- Deserialises 8N1 frames from the board RX pin using a 16x oversampling tick supplied by the shared baud-rate generator.
- Presents each good byte with a one-cycle done strobe. The interface block latches these bytes as operand A, operand B and opcode.
- Flags frames whose stop bit is low.

Parameters:
- DBIT, 8, data bits per frame (LSB first).
- SB_TICK, 16, oversampling ticks spent in stop bit (16 = 1 stop bit).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- i_rx  input  1  asynchronous serial line, idle high.
- i_s_tick  input  1  oversampling enable, one clk wide, 16 per bit period.
- o_dout  output  DBIT  last correctly received byte.
- o_rx_done_tick  output  1  one-cycle strobe: new byte on o_dout.
- o_frame_err  output  1  one-cycle strobe: stop bit sampled low.

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on rising clk; reset has priority over everything.
- Reset values:
  - o_dout=0, o_rx_done_tick=0, o_frame_err=0.
  - Both synchroniser flops =1; state=IDLE.
  - s_cnt=0, n_cnt=0, shift register=0.
- i_rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s. This adds 2 clk of latency.
- Counters:
  - s_cnt is 4 bits and counts i_s_tick pulses.
  - n_cnt is $clog2(DBIT) bits and counts data bits.
  - Counters advance only in cycles with i_s_tick=1.
- FSM:
  - IDLE: when rx_s==0, go to START with s_cnt=0. Ticks are ignored in IDLE.
  - START: on tick with s_cnt==7 (mid start bit):
    - If rx_s==0: go to DATA with s_cnt=0, n_cnt=0.
    - Else (glitch/false start): return to IDLE, no strobe.
    - On other ticks: s_cnt++.
  - DATA: on tick with s_cnt==15 (mid data bit):
    - shift <= {rx_s, shift[DBIT-1:1]}; s_cnt=0.
    - If n_cnt==DBIT-1, go to STOP with s_cnt=0; else n_cnt++.
    - On other ticks: s_cnt++.
  - STOP: on tick with s_cnt==SB_TICK-1, go to IDLE and sample rx_s:
    - rx_s==1: o_dout<=shift and o_rx_done_tick=1 for the next single clk.
    - rx_s==0: o_frame_err=1 for the next single clk; o_dout unchanged; no done strobe.
    - On other ticks: s_cnt++.
- Strobes are registered:
  - Each is high exactly one clk, in the cycle after the deciding tick.
  - They are never both high.
  - They are low in every other cycle, including while i_s_tick is held high continuously.
- o_dout holds its value until the next good frame.
- Back-to-back frames: a start bit immediately following the stop bit is accepted. IDLE re-arms in the same clk the strobe is issued.
- Line held low (break): produces a frame error, then the FSM stays in IDLE until rx_s returns high, then falls low again. A new START requires a 1→0 transition; track the previous rx_s.
- Reset mid-frame: the partial byte is discarded, no strobe is issued, and all reset values apply on the next cycle.
- i_s_tick asserted in consecutive clks is legal; each cycle counts as one tick.
- Whole-frame latency: ≈(1+DBIT)*16 + SB_TICK − 8 ticks after the start-bit falling edge, plus 3 clk (synchroniser and output register).

Test Plan:
- i_s_tick tied 1 (bit = 16 clk); send 0xA5 as 8N1 → exactly one o_rx_done_tick pulse, o_dout=8'hA5, o_frame_err never high.
- Send 0x03, 0x05, 0x20 back-to-back with zero idle → three done pulses in order with o_dout 0x03, 0x05, 0x20. This matches the interface block capturing A=3, B=5, opcode=ADD.
- Drive i_rx low for 4 clk then high (glitch) → FSM returns to IDLE, no strobe, o_dout keeps previous value.
- Send 0x5A with stop bit forced low → one o_frame_err pulse, no done pulse, o_dout unchanged. The following good 0x11 gives a done pulse with o_dout=0x11.
- Assert reset for 1 clk during data bit 4 of 0xFF → outputs zero next cycle, no strobe. The next frame 0x3C is received correctly.
- i_s_tick every 5th clk (tick period 5); send 0x81 → done pulse, o_dout=0x81, and the pulse width is 1 clk, not 5.
